// File: rtl/arb_types.sv
// Shared types for the memory arbiter.
//   arb_state_t : arbiter FSM state (idle, instruction owner, data owner)
//   arb_op_t    : memory operation latched at grant
package arb_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_INST,
        ARB_DATA
    } arb_state_t;

    typedef enum logic {
        ARB_OP_READ,
        ARB_OP_WRITE
    } arb_op_t;

endpackage

// File: rtl/arb_grant.sv
// Grant selection for the memory arbiter: data wins over instruction unless
// the instruction side has been passed over STARVE_LIMIT times in a row.
// Ports:
//   inst_read   in  instruction request pending
//   data_req    in  data read or write pending
//   starve_cnt  in  consecutive data grants taken while inst was waiting
//   grant_inst  out select instruction requester
//   grant_data  out select data requester
module arb_grant #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             inst_read,
    input  logic             data_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_inst,
    output logic             grant_data
);

    logic starved;

    // A limit of zero disables the guard entirely.
    assign starved    = inst_read && (STARVE_LIMIT != 0) &&
                        (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign grant_data = data_req && !starved;
    assign grant_inst = inst_read && !grant_data;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical memory port between the instruction-fetch and the
// load/store requesters. One transaction in flight; the request is latched
// at grant and held on the pmem bus until pmem_resp.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_read/inst_address        instruction request (level)
//   inst_resp/inst_rdata          instruction completion pulse and data
//   data_read/data_write/...      data request (level), byte enables, wdata
//   data_resp/data_rdata          data completion pulse and data
//   pmem_*                        physical memory port
module mem_arbiter
    import arb_types::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_read,
    input  logic [31:0]             inst_address,
    output logic                    inst_resp,
    output logic [DATA_WIDTH-1:0]   inst_rdata,
    input  logic                    data_read,
    input  logic                    data_write,
    input  logic [DATA_WIDTH/8-1:0] data_mbe,
    input  logic [31:0]             data_address,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic                    data_resp,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [DATA_WIDTH/8-1:0] pmem_byte_enable,
    output logic [31:0]             pmem_address,
    output logic [DATA_WIDTH-1:0]   pmem_wdata,
    input  logic                    pmem_resp,
    input  logic [DATA_WIDTH-1:0]   pmem_rdata
);

    // Counter must be able to hold STARVE_LIMIT itself.
    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_inst;
    logic             grant_data;
    arb_op_t          data_op;

    arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_grant (
        .inst_read  (inst_read),
        .data_req   (data_read || data_write),
        .starve_cnt (starve_cnt),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    // Read takes precedence when both data strobes are (illegally) high.
    assign data_op = data_read ? ARB_OP_READ : ARB_OP_WRITE;

    // Completion is combinational so the owner sees resp in the pmem_resp cycle.
    assign inst_resp  = (state == ARB_INST) && pmem_resp;
    assign data_resp  = (state == ARB_DATA) && pmem_resp;
    assign inst_rdata = pmem_rdata;
    assign data_rdata = pmem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ARB_IDLE;
            starve_cnt       <= '0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_byte_enable <= '0;
            pmem_address     <= '0;
            pmem_wdata       <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_data) begin
                        state        <= ARB_DATA;
                        pmem_address <= data_address;
                        if (data_op == ARB_OP_READ) begin
                            pmem_read        <= 1'b1;
                            pmem_byte_enable <= '1;
                        end else begin
                            pmem_write       <= 1'b1;
                            pmem_byte_enable <= data_mbe;
                            pmem_wdata       <= data_wdata;
                        end
                        // Count only grants that actually bypassed a waiting fetch.
                        if (!inst_read)
                            starve_cnt <= '0;
                        else if (starve_cnt != CNT_W'(STARVE_LIMIT))
                            starve_cnt <= starve_cnt + CNT_W'(1);
                    end else if (grant_inst) begin
                        state            <= ARB_INST;
                        pmem_read        <= 1'b1;
                        pmem_byte_enable <= '1;
                        pmem_address     <= inst_address;
                        starve_cnt       <= '0;
                    end
                end
                ARB_INST, ARB_DATA: begin
                    // Always return through idle so a requester that drops
                    // after resp is not granted a second time.
                    if (pmem_resp) begin
                        state      <= ARB_IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state      <= ARB_IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import arb_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_read;
    logic [31:0] inst_address;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_address;
    logic [31:0] data_wdata;
    logic        data_resp;
    logic [31:0] data_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic        pmem_resp;
    logic [31:0] pmem_rdata;

    int checks = 0;
    int errors = 0;
    int illegal_seen = 0;
    int dresp_cnt;

    mem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_read        (inst_read),
        .inst_address     (inst_address),
        .inst_resp        (inst_resp),
        .inst_rdata       (inst_rdata),
        .data_read        (data_read),
        .data_write       (data_write),
        .data_mbe         (data_mbe),
        .data_address     (data_address),
        .data_wdata       (data_wdata),
        .data_resp        (data_resp),
        .data_rdata       (data_rdata),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_resp        (pmem_resp),
        .pmem_rdata       (pmem_rdata)
    );

    always #5 clk = ~clk;

    // Both data strobes high is illegal stimulus; flag every occurrence.
    always @(negedge clk)
        if (!rst && data_read && data_write) illegal_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        inst_read = 0; inst_address = 0;
        data_read = 0; data_write = 0; data_mbe = 0; data_address = 0; data_wdata = 0;
        pmem_resp = 0; pmem_rdata = 0;
        tick(); tick();
        mid();
        chk("rst_read",  32'(pmem_read), 32'd0);
        chk("rst_write", 32'(pmem_write), 32'd0);
        chk("rst_be",    32'(pmem_byte_enable), 32'd0);
        chk("rst_addr",  pmem_address, 32'd0);
        chk("rst_wdata", pmem_wdata, 32'd0);
        chk("rst_resp",  32'({inst_resp, data_resp}), 32'd0);
        tick();
        rst = 1'b0;

        // ---- Inst only ----
        inst_read = 1; inst_address = 32'h60;            // cycle 0
        mid(); chk("i0_idle_read", 32'(pmem_read), 32'd0);
        tick();                                           // cycle 1
        mid();
        chk("i1_read", 32'(pmem_read), 32'd1);
        chk("i1_addr", pmem_address, 32'h60);
        chk("i1_be",   32'(pmem_byte_enable), 32'hF);
        tick();                                           // cycle 2
        mid(); chk("i2_noresp", 32'(inst_resp), 32'd0);
        tick();                                           // cycle 3
        pmem_resp = 1; pmem_rdata = 32'h00000013;
        mid();
        chk("i3_resp",  32'(inst_resp), 32'd1);
        chk("i3_rdata", inst_rdata, 32'h13);
        chk("i3_dresp", 32'(data_resp), 32'd0);
        tick();                                           // cycle 4
        pmem_resp = 0; inst_read = 0;
        mid();
        chk("i4_read", 32'(pmem_read), 32'd0);
        chk("i4_resp", 32'(inst_resp), 32'd0);
        tick();

        // ---- Simultaneous: data wins ----
        inst_read = 1; inst_address = 32'h64;
        data_write = 1; data_address = 32'h100; data_wdata = 32'hDEADBEEF; data_mbe = 4'b0011;
        tick();                                           // cycle 1: data
        pmem_resp = 1;
        mid();
        chk("s1_write", 32'(pmem_write), 32'd1);
        chk("s1_read",  32'(pmem_read), 32'd0);
        chk("s1_be",    32'(pmem_byte_enable), 32'h3);
        chk("s1_addr",  pmem_address, 32'h100);
        chk("s1_wdata", pmem_wdata, 32'hDEADBEEF);
        chk("s1_dresp", 32'(data_resp), 32'd1);
        chk("s1_iresp", 32'(inst_resp), 32'd0);
        tick();                                           // cycle 2: idle
        pmem_resp = 0; data_write = 0;
        mid();
        chk("s2_idle", 32'({pmem_read, pmem_write}), 32'd0);
        tick();                                           // cycle 3: inst
        pmem_resp = 1; pmem_rdata = 32'h11;
        mid();
        chk("s3_read", 32'(pmem_read), 32'd1);
        chk("s3_addr", pmem_address, 32'h64);
        chk("s3_be",   32'(pmem_byte_enable), 32'hF);
        chk("s3_iresp", 32'(inst_resp), 32'd1);
        tick();
        pmem_resp = 0; inst_read = 0;
        tick();

        // ---- Starvation, limit 2: D, D, I, D ----
        inst_read = 1; inst_address = 32'h68;
        data_read = 1; data_address = 32'h400;
        tick();                                           // D #1
        pmem_resp = 1;
        mid();
        chk("st_d1_addr", pmem_address, 32'h400);
        chk("st_d1_resp", 32'(data_resp), 32'd1);
        tick();                                           // idle
        pmem_resp = 0; data_address = 32'h404;
        mid(); chk("st_idle1", 32'(pmem_read), 32'd0);
        tick();                                           // D #2
        pmem_resp = 1;
        mid();
        chk("st_d2_addr", pmem_address, 32'h404);
        chk("st_d2_resp", 32'(data_resp), 32'd1);
        tick();                                           // idle: inst forced
        pmem_resp = 0; data_address = 32'h408;
        tick();                                           // I
        pmem_resp = 1;
        mid();
        chk("st_i_addr", pmem_address, 32'h68);
        chk("st_i_resp", 32'(inst_resp), 32'd1);
        chk("st_i_dresp", 32'(data_resp), 32'd0);
        chk("st_cnt_clr", 32'(dut.starve_cnt), 32'd0);
        tick();                                           // idle
        pmem_resp = 0; inst_read = 0;
        tick();                                           // D resumes
        pmem_resp = 1;
        mid();
        chk("st_d3_addr", pmem_address, 32'h408);
        chk("st_d3_read", 32'(pmem_read), 32'd1);
        chk("st_d3_resp", 32'(data_resp), 32'd1);
        tick();
        pmem_resp = 0; data_read = 0;
        tick();

        // ---- Mid-transaction drop ----
        data_read = 1; data_address = 32'h200;
        dresp_cnt = 0;
        tick();                                           // cycle 1: granted
        data_read = 0;
        mid();
        chk("md_addr", pmem_address, 32'h200);
        chk("md_read", 32'(pmem_read), 32'd1);
        tick(); mid(); if (data_resp) dresp_cnt++;
        tick(); mid(); if (data_resp) dresp_cnt++;
        tick();                                           // respond
        pmem_resp = 1;
        mid(); if (data_resp) dresp_cnt++;
        tick();
        pmem_resp = 0;
        mid(); if (data_resp) dresp_cnt++;
        tick();
        mid(); if (data_resp) dresp_cnt++;
        chk("md_resp_once", 32'(dresp_cnt), 32'd1);
        chk("md_no_regrant", 32'({pmem_read, pmem_write}), 32'd0);
        tick();

        // ---- Reset mid-op ----
        data_write = 1; data_address = 32'h500; data_wdata = 32'hCAFE0001; data_mbe = 4'hF;
        tick();                                           // in ARB_DATA
        mid(); chk("rm_write", 32'(pmem_write), 32'd1);
        rst = 1; data_write = 0;
        tick();
        rst = 0;
        mid();
        chk("rm_strobes", 32'({pmem_read, pmem_write}), 32'd0);
        chk("rm_be",   32'(pmem_byte_enable), 32'd0);
        chk("rm_addr", pmem_address, 32'd0);
        chk("rm_wdata", pmem_wdata, 32'd0);
        tick();                                           // late response
        pmem_resp = 1;
        mid();
        chk("rm_no_dresp", 32'(data_resp), 32'd0);
        chk("rm_no_iresp", 32'(inst_resp), 32'd0);
        tick();
        pmem_resp = 0;
        mid();
        chk("rm_state", 32'(dut.state), 32'(ARB_IDLE));
        chk("rm_idle", 32'({pmem_read, pmem_write}), 32'd0);
        tick();

        // ---- Illegal read+write ----
        data_read = 1; data_write = 1; data_address = 32'h300; data_mbe = 4'h5;
        tick();
        data_read = 0; data_write = 0;
        pmem_resp = 1;
        mid();
        chk("il_read",  32'(pmem_read), 32'd1);
        chk("il_write", 32'(pmem_write), 32'd0);
        chk("il_be",    32'(pmem_byte_enable), 32'hF);
        chk("il_addr",  pmem_address, 32'h300);
        chk("il_flag",  32'(illegal_seen), 32'd1);
        tick();
        pmem_resp = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
